// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: the fetch-side bundle: instruction memory port, redirect request and decode handshake.
interface ifetch_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    // master = the fetch queue, slave = memory/decode/branch environment
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        output count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        input  count
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the PC, fetches from a combinational-read imem and buffers {pc, instr} toward decode.
// Define IFETCH_PERF_EN to add saturating perf_fetched / perf_stall counters.
module ifetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);
    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic out_valid_c;
    logic pop_c;
    logic push_c;

    assign out_valid_c = (count_q != '0);
    assign pop_c       = out_valid_c & bus.out_ready;
    // A full queue still accepts a fetch when decode drains the head in the same cycle
    assign push_c      = ~bus.redirect_valid & ((count_q < FULL_CNT) | pop_c);

    // Next-state: redirect flushes the queue and reloads the PC; otherwise push/pop bookkeeping
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + ADDR_W'(PC_STEP);
            end
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: unread slots are masked by count
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            pc_mem_q[tail_q]    <= pc_q;
            instr_mem_q[tail_q] <= bus.imem_data;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = out_valid_c ? pc_mem_q[head_q]    : '0;
    assign bus.out_instr = out_valid_c ? instr_mem_q[head_q] : '0;
    assign bus.count     = count_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Saturating counters: fetches issued and cycles lost to a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push_c && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (!bus.redirect_valid && !push_c && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule
